// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: memory-mapped receive controller between the UART receiver and the
// CPU data-memory bus. Captures received bytes into a small FIFO and exposes DATA,
// STATUS and CTRL registers. Overrun is sticky, and the interrupt is a level output.
// Optional feature macro: UART_RX_CTRL_IRQ_EN
//   defined   -> irq_en register in CTRL bit0, o_irq driven
//   undefined -> no irq_en logic, CTRL bit0 reads 0, o_irq tied low
module uart_rx_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_status,
    input  logic [3:0]  i_addr,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] LastPtr = CW'(DEPTH - 1);
    localparam logic [CW-1:0] OneC    = CW'(1);

    localparam logic [1:0] SelData   = 2'd0;
    localparam logic [1:0] SelStatus = 2'd1;
    localparam logic [1:0] SelCtrl   = 2'd2;

    // State
    logic [7:0]    r_mem [DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overrun;
    logic          r_rx_status_d;

    // Decode and control
    logic [1:0]    w_sel;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_ctrl_wr;
    logic          w_flush;
    logic          w_clr_ovr;
    logic          w_push_ok;
    logic          w_overrun_set;
    logic          w_irq_en;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic [4:0]    w_count5;

    // Next-state
    logic [CW-1:0] w_wr_ptr_d;
    logic [CW-1:0] w_rd_ptr_d;
    logic [CW-1:0] w_count_d;
    logic          w_overrun_d;

    assign w_sel     = i_addr[3:2];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DepthC);
    assign w_wr_idx  = r_wr_ptr[AW-1:0];
    assign w_rd_idx  = r_rd_ptr[AW-1:0];
    assign w_count5  = 5'(r_count);

    // Rising-edge detect so a wide strobe pushes exactly once
    assign w_push    = i_rx_status & ~r_rx_status_d;
    assign w_pop     = i_rd_en && (w_sel == SelData) && !w_empty;
    assign w_ctrl_wr = i_wr_en && (w_sel == SelCtrl);
    assign w_flush   = w_ctrl_wr && i_wdata[2];
    assign w_clr_ovr = w_ctrl_wr && i_wdata[1];

    // A pop in the same cycle frees a slot, so a push at full still lands
    assign w_push_ok     = w_push && !w_flush && (!w_full || w_pop);
    // Flush drops the byte silently rather than flagging it as overrun
    assign w_overrun_set = w_push && !w_flush && w_full && !w_pop;

    // Pointer, count and overrun next-state
    always_comb begin
        w_wr_ptr_d  = r_wr_ptr;
        w_rd_ptr_d  = r_rd_ptr;
        w_count_d   = r_count;
        w_overrun_d = r_overrun;
        if (w_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_push_ok) begin
                w_wr_ptr_d = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + OneC;
            end
            if (w_pop) begin
                w_rd_ptr_d = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + OneC;
            end
            w_count_d = r_count + CW'(w_push_ok) - CW'(w_pop);
        end
        // Set beats clear when both happen in one cycle
        if (w_overrun_set) begin
            w_overrun_d = 1'b1;
        end else if (w_clr_ovr) begin
            w_overrun_d = 1'b0;
        end
    end

    // Control state register; strobe history forced high in reset to block a push on release
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overrun     <= 1'b0;
            r_rx_status_d <= 1'b1;
        end else begin
            r_wr_ptr      <= w_wr_ptr_d;
            r_rd_ptr      <= w_rd_ptr_d;
            r_count       <= w_count_d;
            r_overrun     <= w_overrun_d;
            r_rx_status_d <= i_rx_status;
        end
    end

    // FIFO storage write; contents are not reset
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push_ok) begin
            r_mem[w_wr_idx] <= i_rx_data;
        end
    end

`ifdef UART_RX_CTRL_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_irq_en_d;

    assign w_irq_en_d = w_ctrl_wr ? i_wdata[0] : r_irq_en;
    assign w_irq_en   = r_irq_en;
    assign o_irq      = r_irq;

    // Interrupt enable and level request, computed from post-edge state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_irq_en <= w_irq_en_d;
            r_irq    <= w_irq_en_d & (w_count_d != '0);
        end
    end
`else
    assign w_irq_en = 1'b0;
    assign o_irq    = 1'b0;
`endif

    // Load data mux; zero whenever no load is in progress
    always_comb begin
        o_rdata = '0;
        if (i_rd_en) begin
            case (w_sel)
                SelData: begin
                    if (!w_empty) begin
                        o_rdata = {24'b0, r_mem[w_rd_idx]};
                    end
                end
                SelStatus: o_rdata = {24'b0, w_count5, r_overrun, w_full, ~w_empty};
                SelCtrl:   o_rdata = {31'b0, w_irq_en};
                default:   o_rdata = '0;
            endcase
        end
    end

    // Address LSBs and upper store bits have no function
    logic w_unused;
    assign w_unused = ^{i_addr[1:0], i_wdata[31:3], i_wdata[0]};

endmodule
